// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, halt encoding, buffer sizing and fetch states
package instr_fetch_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 15;
  localparam int BUF_DEPTH = 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  localparam logic [DATA_W-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, memory-port and instruction-stream signals of the fetch unit
interface instr_fetch_if #(
  parameter int addr_w = instr_fetch_pkg::ADDR_W,
  parameter int data_w = instr_fetch_pkg::DATA_W
);

  logic              start;
  logic [addr_w-1:0] start_addr;
  logic [addr_w-1:0] imem_addr;
  logic [data_w-1:0] imem_data;
  logic              br_taken;
  logic [addr_w-1:0] br_target;
  logic [data_w-1:0] instr;
  logic [addr_w-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;

  modport master (
    input  start, start_addr, imem_data, br_taken, br_target, instr_ready,
    output imem_addr, instr, instr_pc, instr_valid, busy
  );

  modport slave (
    output start, start_addr, imem_data, br_taken, br_target, instr_ready,
    input  imem_addr, instr, instr_pc, instr_valid, busy
  );

endinterface

// File: rtl/instr_fetch_buf.sv
// rtl/instr_fetch_buf.sv - fetch_buf: in-order {word, pc} FIFO with flush
module fetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int addr_w = ADDR_W,
  parameter int data_w = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [data_w-1:0] push_word,
  input  logic [addr_w-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [data_w-1:0] head_word,
  output logic [addr_w-1:0] head_pc,
  output logic [CNT_W-1:0]  count
);

  logic [data_w-1:0] word_q [BUF_DEPTH];
  logic [addr_w-1:0] pc_q   [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A pop in the flush cycle has already been taken by the consumer; all else is dropped.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= push_word;
        pc_q[wr_ptr]   <= push_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_word = word_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: one read in flight, 2-entry buffer, branch redirect, halt drain
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int addr_w = ADDR_W,
  parameter int data_w = DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);

  localparam logic [data_w-1:0] halt_word = '1;

  state_t            state;
  state_t            state_nxt;
  logic [addr_w-1:0] fetch_pc;
  logic [addr_w-1:0] addr_hold;
  logic [addr_w-1:0] flight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic [data_w-1:0] head_word;
  logic [addr_w-1:0] head_pc;
  logic              pop;
  logic              redirect;
  logic              issue;
  logic              capture;
  logic              halt_cap;

  assign pop      = (count != '0) && bus.instr_ready;
  assign redirect = bus.br_taken && (state != IDLE);
  assign occ      = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue    = (state == FETCH) && !bus.br_taken && (occ < (CNT_W+1)'(BUF_DEPTH));
  assign capture  = inflight && (state == FETCH) && !bus.br_taken;
  assign halt_cap = capture && (bus.imem_data == halt_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = FETCH;
      FETCH:   if (bus.br_taken) state_nxt = FETCH;
               else if (halt_cap) state_nxt = DRAIN;
      DRAIN:   if (bus.br_taken) state_nxt = FETCH;
               else if (count == '0 || (count == CNT_W'(1) && pop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The address is presented in the issue cycle itself so the registered memory answers in time
  // for the 2-cycle start-to-valid latency; otherwise the last issued address is held.
  always_comb begin
    bus.busy        = (state != IDLE);
    bus.imem_addr   = issue ? fetch_pc : addr_hold;
    bus.instr       = head_word;
    bus.instr_pc    = head_pc;
    bus.instr_valid = (count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= '0;
      addr_hold <= '0;
      flight_pc <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_hold <= fetch_pc;
        flight_pc <= fetch_pc;
      end
      if (state == IDLE && bus.start) fetch_pc <= bus.start_addr;
      else if (redirect)              fetch_pc <= bus.br_target;
      else if (issue)                 fetch_pc <= fetch_pc + addr_w'(1);
    end
  end

  fetch_buf #(
    .addr_w (addr_w),
    .data_w (data_w)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_word (bus.imem_data),
    .push_pc   (flight_pc),
    .pop       (pop),
    .flush     (redirect),
    .head_word (head_word),
    .head_pc   (head_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch with a registered 256x15 memory
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  logic [14:0] mem [256];

  instr_fetch_if #(.addr_w(8), .data_w(15)) ifc ();

  instr_fetch #(.addr_w(8), .data_w(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ifc.imem_data <= mem[ifc.imem_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_word(input logic [7:0] pc);
    chk($sformatf("valid@%0h", pc), 32'(ifc.instr_valid), 32'd1);
    chk($sformatf("pc@%0h", pc), 32'(ifc.instr_pc), 32'(pc));
    chk($sformatf("instr@%0h", pc), 32'(ifc.instr), 32'(mem[pc]));
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(ifc.instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_imem_addr"}, 32'(ifc.imem_addr), 32'd0);
    chk({tag, "_instr"}, 32'(ifc.instr), 32'd0);
    chk({tag, "_instr_pc"}, 32'(ifc.instr_pc), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 15'(16'h1000 + a * 3);
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.start_addr = '0;
    ifc.br_taken = 1'b0;
    ifc.br_target = '0;
    ifc.instr_ready = 1'b1;
    tick();
    tick();
    expect_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(ifc.busy), 32'd0);

    // streaming from 0x10, with a start pulse mid-stream that must be ignored
    ifc.start = 1'b1;
    ifc.start_addr = 8'h10;
    tick();
    ifc.start = 1'b0;
    chk("lat0_valid", 32'(ifc.instr_valid), 32'd0);
    chk("lat0_busy", 32'(ifc.busy), 32'd1);
    tick();
    chk("lat1_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_word(8'h10 + 8'(k));
      ifc.start = (k == 1);
      ifc.start_addr = 8'h80;
      tick();
    end
    ifc.start = 1'b0;

    // backpressure: head frozen for 5 cycles, then no loss or duplication
    expect_word(8'h14);
    ifc.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_word(8'h14);
    end
    ifc.instr_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_word(8'h14 + 8'(k));
    end

    // branch mid-stream to 0x40
    ifc.br_taken = 1'b1;
    ifc.br_target = 8'h40;
    tick();
    ifc.br_taken = 1'b0;
    chk("br_gap0_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    chk("br_gap1_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_word(8'h40);
    tick();
    expect_word(8'h41);
    tick();
    expect_word(8'h42);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    expect_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("postrst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("postrst_busy", 32'(ifc.busy), 32'd0);

    // address wrap FE, FF, 00, 01
    ifc.start = 1'b1;
    ifc.start_addr = 8'hFE;
    tick();
    ifc.start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_word(8'hFE + 8'(k));
      tick();
    end

    // halt at 0x05
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem[5] = HALT_WORD;
    tick();
    ifc.start = 1'b1;
    ifc.start_addr = 8'h00;
    tick();
    ifc.start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      expect_word(8'(k));
      tick();
    end
    chk("halt_busy", 32'(ifc.busy), 32'd0);
    chk("halt_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    tick();
    chk("halt_idle_valid", 32'(ifc.instr_valid), 32'd0);
    chk("halt_idle_busy", 32'(ifc.busy), 32'd0);
    chk("halt_addr_hold", 32'(ifc.imem_addr), 32'h06);

    // branch in IDLE is ignored
    ifc.br_taken = 1'b1;
    ifc.br_target = 8'h40;
    tick();
    ifc.br_taken = 1'b0;
    chk("idle_br_busy", 32'(ifc.busy), 32'd0);
    tick();
    tick();
    chk("idle_br_valid", 32'(ifc.instr_valid), 32'd0);

    // branch coincident with the HALT_WORD capture overrides the halt
    ifc.start = 1'b1;
    ifc.start_addr = 8'h00;
    tick();
    ifc.start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      expect_word(8'(k));
      if (k == 4) begin
        ifc.br_taken = 1'b1;
        ifc.br_target = 8'h40;
      end
      tick();
    end
    ifc.br_taken = 1'b0;
    chk("hb_gap0_valid", 32'(ifc.instr_valid), 32'd0);
    chk("hb_gap0_busy", 32'(ifc.busy), 32'd1);
    tick();
    chk("hb_gap1_valid", 32'(ifc.instr_valid), 32'd0);
    chk("hb_gap1_busy", 32'(ifc.busy), 32'd1);
    tick();
    expect_word(8'h40);
    tick();
    expect_word(8'h41);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
